// File: rtl/arisco_pkg.sv
// Shared types and constants for the multi-cycle fetch sequencer and its next-PC logic.
package arisco_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_HALT  = 3'd3,
    ST_FAULT = 3'd4
  } seq_state_t;

  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

  localparam logic [1:0] FAULT_NONE        = 2'b00;
  localparam logic [1:0] FAULT_TIMEOUT     = 2'b01;
  localparam logic [1:0] FAULT_MISALIGN    = 2'b10;
  localparam logic [1:0] FAULT_UNSUPPORTED = 2'b11;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/next_pc_unit.sv
// Combinational next-PC decode: JAL target, sequential pc+4 and control-flow classification.
module next_pc_unit
  import arisco_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] instruction_i,
  output logic [31:0] target_o,
  output logic [31:0] pc_plus4_o,
  output logic        misaligned_o,
  output logic        is_halt_o,
  output logic        is_unsupported_o
);

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic signed [31:0] jal_off;
  logic               unused_rd;

  assign opcode    = instruction_i[6:0];
  assign funct3    = instruction_i[14:12];
  assign unused_rd = ^instruction_i[11:7];

  // J-type immediate, sign-extended from bit 20 of the offset.
  assign jal_off = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                    instruction_i[20], instruction_i[30:21], 1'b0};

  assign pc_plus4_o       = pc_i + 32'd4;
  assign target_o         = (opcode == OPCODE_JAL) ? (pc_i + $unsigned(jal_off)) : pc_plus4_o;
  assign misaligned_o     = (target_o[1:0] != 2'b00);
  assign is_halt_o        = (opcode == OPCODE_SYSTEM) && (funct3 == 3'b000);
  assign is_unsupported_o = (opcode == OPCODE_BRANCH) || (opcode == OPCODE_JALR);

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle sequencer: fetches over a req/ready handshake, strobes one execute cycle per instruction.
module fetch_sequencer
  import arisco_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] pc_next,
  output logic        exec_valid,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  localparam int TO_W = $clog2(FETCH_TIMEOUT + 1);

  seq_state_t        state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [1:0]        cause_q, cause_d;

  logic [31:0]       target;
  logic [31:0]       pc_plus4;
  logic              misaligned;
  logic              is_halt;
  logic              is_unsupported;

  next_pc_unit u_next_pc (
    .pc_i             (pc_q),
    .instruction_i    (instr_q),
    .target_o         (target),
    .pc_plus4_o       (pc_plus4),
    .misaligned_o     (misaligned),
    .is_halt_o        (is_halt),
    .is_unsupported_o (is_unsupported)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // Ready on the expiring cycle takes priority over the timeout.
        if (imem_ready) begin
          instr_d = imem_rdata;
          cnt_d   = '0;
          state_d = ST_EXEC;
        end else if (cnt_q == TO_W'(FETCH_TIMEOUT - 1)) begin
          cnt_d   = cnt_q + 1'b1;
          cause_d = FAULT_TIMEOUT;
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_EXEC: begin
        if (is_halt) begin
          state_d = ST_HALT;
        end else if (is_unsupported) begin
          cause_d = FAULT_UNSUPPORTED;
          state_d = ST_FAULT;
        end else if (misaligned) begin
          cause_d = FAULT_MISALIGN;
          state_d = ST_FAULT;
        end else begin
          pc_d    = target;
          state_d = run ? ST_FETCH : ST_IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= INSTR_NOP;
      cnt_q   <= '0;
      cause_q <= FAULT_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  // Request is decoded straight from state so an async reset drops it immediately.
  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = imem_req ? pc_q : 32'h0;
  assign instruction = instr_q;
  assign pc          = pc_q;
  assign pc_next     = pc_plus4;
  assign exec_valid  = (state_q == ST_EXEC);
  assign halted      = (state_q == ST_HALT);
  assign fault       = (state_q == ST_FAULT);
  assign fault_cause = cause_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: each task drives one scenario and checks hand-computed values.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        exec_valid;
  logic        halted;
  logic        fault;
  logic [1:0]  fault_cause;

  int tests_run = 0;
  int tests_failed = 0;

  fetch_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .pc          (pc),
    .pc_next     (pc_next),
    .exec_valid  (exec_valid),
    .halted      (halted),
    .fault       (fault),
    .fault_cause (fault_cause)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Waits (bounded) for a request, records its address, answers after 'delay' idle cycles.
  task automatic serve(input logic [31:0] word, input int delay,
                       output logic [31:0] addr, output bit got);
    got = 1'b0;
    addr = 32'h0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (imem_req) begin
        got = 1'b1;
        addr = imem_addr;
      end else begin
        tick();
      end
    end
    if (got) begin
      repeat (delay) tick();
      imem_ready = 1'b1;
      imem_rdata = word;
      tick();
      imem_ready = 1'b0;
      imem_rdata = 32'h0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tests_run++;
    if (imem_req !== 1'b0 || exec_valid !== 1'b0 || halted !== 1'b0 || fault !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got req=%b ev=%b h=%b f=%b required all 0", imem_req, exec_valid, halted, fault);
    end
    tests_run++;
    if (pc !== 32'h0 || instruction !== 32'h13 || fault_cause !== 2'b00 || imem_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_data: got pc=%h instr=%h cause=%b addr=%h required 0/00000013/00/0", pc, instruction, fault_cause, imem_addr);
    end
    do_reset();
    tick();
    tests_run++;
    if (imem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_no_run: got imem_req=%b required 0", imem_req);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] words [4] = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193, 32'h0040_0213};
    logic [31:0] a;
    bit g;
    do_reset();
    run = 1'b1;
    for (int k = 0; k < 4; k++) begin
      serve(words[k], 1, a, g);
      tests_run++;
      if (!g || a !== 32'(k * 4)) begin
        tests_failed++;
        $display("FAIL seq_addr[%0d]: got got=%b addr=%h required 1/%h", k, g, a, 32'(k * 4));
      end
      tests_run++;
      if (exec_valid !== 1'b1 || instruction !== words[k] || pc !== 32'(k * 4) || pc_next !== 32'(k * 4 + 4)) begin
        tests_failed++;
        $display("FAIL seq_exec[%0d]: got ev=%b instr=%h pc=%h pcn=%h required 1/%h/%h/%h",
                 k, exec_valid, instruction, pc, pc_next, words[k], 32'(k * 4), 32'(k * 4 + 4));
      end
      if (k < 3) begin
        tick();
        tests_run++;
        if (exec_valid !== 1'b0 || imem_req !== 1'b1) begin
          tests_failed++;
          $display("FAIL seq_pulse[%0d]: got ev=%b req=%b required 0/1", k, exec_valid, imem_req);
        end
      end
    end
  endtask

  task automatic test_jal();
    logic [31:0] a;
    bit g;
    serve(32'h0080_006F, 0, a, g);
    tests_run++;
    if (!g || a !== 32'h10 || exec_valid !== 1'b1 || pc_next !== 32'h14) begin
      tests_failed++;
      $display("FAIL jal_fwd_exec: got got=%b addr=%h ev=%b pcn=%h required 1/10/1/14", g, a, exec_valid, pc_next);
    end
    serve(32'hFF9F_F06F, 0, a, g);
    tests_run++;
    if (!g || a !== 32'h18) begin
      tests_failed++;
      $display("FAIL jal_fwd_target: got got=%b addr=%h required 1/18", g, a);
    end
    serve(32'h0000_0013, 0, a, g);
    tests_run++;
    if (!g || a !== 32'h10) begin
      tests_failed++;
      $display("FAIL jal_back_target: got got=%b addr=%h required 1/10", g, a);
    end
    run = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    logic [31:0] a;
    bit g;
    do_reset();
    run = 1'b1;
    serve(32'hFFDF_F06F, 0, a, g);
    serve(32'h0010_0093, 0, a, g);
    tests_run++;
    if (!g || a !== 32'hFFFF_FFFC || pc_next !== 32'h0) begin
      tests_failed++;
      $display("FAIL wrap_top: got got=%b addr=%h pcn=%h required 1/fffffffc/0", g, a, pc_next);
    end
    serve(32'h0000_0013, 0, a, g);
    tests_run++;
    if (!g || a !== 32'h0 || fault !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_zero: got got=%b addr=%h fault=%b required 1/0/0", g, a, fault);
    end
    run = 1'b0;
  endtask

  task automatic test_misaligned();
    logic [31:0] a;
    bit g;
    do_reset();
    run = 1'b1;
    serve(32'h0020_006F, 0, a, g);
    tests_run++;
    if (!g || exec_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL misal_exec: got got=%b ev=%b required 1/1", g, exec_valid);
    end
    repeat (3) tick();
    tests_run++;
    if (fault !== 1'b1 || fault_cause !== 2'b10 || pc !== 32'h0 || imem_req !== 1'b0 || exec_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL misal_fault: got f=%b cause=%b pc=%h req=%b ev=%b required 1/10/0/0/0", fault, fault_cause, pc, imem_req, exec_valid);
    end
  endtask

  task automatic test_unsupported();
    logic [31:0] a;
    bit g;
    do_reset();
    run = 1'b1;
    serve(32'h0000_8067, 0, a, g);
    tests_run++;
    if (!g || exec_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL jalr_exec: got got=%b ev=%b required 1/1", g, exec_valid);
    end
    tick();
    tests_run++;
    if (fault !== 1'b1 || fault_cause !== 2'b11 || pc !== 32'h0 || halted !== 1'b0) begin
      tests_failed++;
      $display("FAIL jalr_fault: got f=%b cause=%b pc=%h h=%b required 1/11/0/0", fault, fault_cause, pc, halted);
    end
  endtask

  task automatic test_timeout();
    int early = 0;
    do_reset();
    run = 1'b1;
    tick();
    for (int i = 1; i <= 16; i++) begin
      if (i < 16 && (fault !== 1'b0 || imem_req !== 1'b1)) early++;
      tick();
    end
    tests_run++;
    if (early != 0) begin
      tests_failed++;
      $display("FAIL timeout_early: got %0d premature cycles required 0", early);
    end
    tests_run++;
    if (fault !== 1'b1 || fault_cause !== 2'b01 || imem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_fault: got f=%b cause=%b req=%b required 1/01/0", fault, fault_cause, imem_req);
    end
  endtask

  task automatic test_timeout_ready();
    do_reset();
    run = 1'b1;
    tick();
    repeat (15) tick();
    imem_ready = 1'b1;
    imem_rdata = 32'h0050_0293;
    tick();
    imem_ready = 1'b0;
    tests_run++;
    if (fault !== 1'b0 || exec_valid !== 1'b1 || instruction !== 32'h0050_0293) begin
      tests_failed++;
      $display("FAIL timeout_ready: got f=%b ev=%b instr=%h required 0/1/00500293", fault, exec_valid, instruction);
    end
    run = 1'b0;
    tick();
  endtask

  task automatic test_ecall();
    logic [31:0] a;
    bit g;
    int reqs = 0;
    do_reset();
    run = 1'b1;
    serve(32'h0000_0073, 0, a, g);
    tests_run++;
    if (!g || exec_valid !== 1'b1 || halted !== 1'b0) begin
      tests_failed++;
      $display("FAIL ecall_exec: got got=%b ev=%b h=%b required 1/1/0", g, exec_valid, halted);
    end
    tick();
    tests_run++;
    if (halted !== 1'b1 || exec_valid !== 1'b0 || fault !== 1'b0) begin
      tests_failed++;
      $display("FAIL ecall_halt: got h=%b ev=%b f=%b required 1/0/0", halted, exec_valid, fault);
    end
    for (int i = 0; i < 5; i++) begin
      if (imem_req !== 1'b0 || exec_valid !== 1'b0) reqs++;
      tick();
    end
    tests_run++;
    if (reqs != 0 || halted !== 1'b1 || pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL ecall_sticky: got stray=%0d h=%b pc=%h required 0/1/0", reqs, halted, pc);
    end
  endtask

  task automatic test_run_control();
    logic [31:0] a;
    bit g;
    do_reset();
    run = 1'b1;
    tick();
    run = 1'b0;
    serve(32'h0010_0093, 1, a, g);
    tests_run++;
    if (!g || a !== 32'h0 || exec_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL run_drop_exec: got got=%b addr=%h ev=%b required 1/0/1", g, a, exec_valid);
    end
    repeat (3) tick();
    tests_run++;
    if (imem_req !== 1'b0 || pc !== 32'h4 || exec_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL run_drop_idle: got req=%b pc=%h ev=%b required 0/4/0", imem_req, pc, exec_valid);
    end
    run = 1'b1;
    serve(32'h0020_0113, 0, a, g);
    tests_run++;
    if (!g || a !== 32'h4) begin
      tests_failed++;
      $display("FAIL run_resume: got got=%b addr=%h required 1/4", g, a);
    end
    tick();
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      tests_failed++;
      $display("FAIL pre_async: got req=%b addr=%h required 1/8", imem_req, imem_addr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (imem_req !== 1'b0 || pc !== 32'h0 || imem_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL async_reset: got req=%b pc=%h addr=%h required 0/0/0", imem_req, pc, imem_addr);
    end
    tick();
    rst_n = 1'b1;
    run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jal();
    test_wrap();
    test_misaligned();
    test_unsupported();
    test_timeout();
    test_timeout_ready();
    test_ecall();
    test_run_control();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
